// File: rtl/pipeline_latch.sv
// pipeline_latch: valid/ready pipeline stage register with flush, NOP fill and a saturating stall counter.
// Optional macro PIPELINE_LATCH_SKID_EN adds a skid entry so in_ready comes from a register.
module pipeline_latch #(
  parameter int unsigned         BUS_SIZE  = 32,
  parameter logic [BUS_SIZE-1:0] NOP_VALUE = '0,
  parameter int unsigned         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_SIZE-1:0]  data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

`ifdef PIPELINE_LATCH_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
  } state_e;
`endif

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [BUS_SIZE-1:0]    main_q,  main_d;
  logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
  logic                   accept;
  logic                   consume;

`ifdef PIPELINE_LATCH_SKID_EN
  logic [BUS_SIZE-1:0]    skid_q,  skid_d;
  logic                   rdy_q,   rdy_d;

  assign in_ready = rdy_q;
`else
  assign in_ready = !valid_q || out_ready;
`endif

  assign out_valid = valid_q;
  assign data_out  = main_q;
  assign stall_cnt = cnt_q;

  assign accept  = in_valid && in_ready;
  assign consume = valid_q && out_ready;

  // Next-state, datapath and stall-counter update; flush freezes the counter.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    cnt_d   = cnt_q;
`ifdef PIPELINE_LATCH_SKID_EN
    skid_d  = skid_q;
`endif

    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
`ifdef PIPELINE_LATCH_SKID_EN
      skid_d  = NOP_VALUE;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_d  = data_in;
          end
        end
        FULL: begin
          if (consume && accept) begin
            main_d = data_in;
          end else if (consume) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
`ifdef PIPELINE_LATCH_SKID_EN
          else if (accept) begin
            state_d = SKID;
            skid_d  = data_in;
          end
`endif
        end
`ifdef PIPELINE_LATCH_SKID_EN
        SKID: begin
          // in_ready is low here, so only a consume can move the stage.
          if (consume) begin
            state_d = FULL;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
        end
      endcase

      if (valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    valid_d = (state_d != EMPTY);
`ifdef PIPELINE_LATCH_SKID_EN
    rdy_d   = (state_d != SKID);
`endif
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      main_q  <= NOP_VALUE;
      cnt_q   <= '0;
`ifdef PIPELINE_LATCH_SKID_EN
      skid_q  <= NOP_VALUE;
      rdy_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
`ifdef PIPELINE_LATCH_SKID_EN
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
`endif
    end
  end

endmodule
